alu_arb: RTL
============

# alu_arb

Two-requester arbiter that shares the single-cycle-latency `alu` between requester A (execute stage) and requester B (address/auxiliary unit). It accepts operations over valid/ready handshakes and grants at most one per cycle with round-robin priority. It drives the ALU operand and opcode inputs, tracks the in-flight result, and returns each result to its originator through a per-requester response slot with backpressure. The ALU's `zeroflag` output is not used; the arbiter computes the zero flag itself from `alu_rd`.

## Interface
Parameters:
- `W`, 32, datapath width; must match the ALU.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `a_req_valid`, `b_req_valid`  in  1  the requester has an operation to issue.
- `a_req_ready`, `b_req_ready`  out  1  the operation is granted this cycle.
- `a_req_op`, `b_req_op`  in  3  ALU opcode.
- `a_req_sr1`, `a_req_sr2`, `b_req_sr1`, `b_req_sr2`  in  W  operands.
- `a_req_shift`, `b_req_shift`  in  W  shift/rotate amount.
- `a_rsp_valid`, `b_rsp_valid`  out  1  a result is held in the slot.
- `a_rsp_ready`, `b_rsp_ready`  in  1  the requester consumes the result.
- `a_rsp_rd`, `b_rsp_rd`  out  W  result.
- `a_rsp_zero`, `b_rsp_zero`  out  1  asserted when the result equals 0.
- `alu_sr1`, `alu_sr2`, `alu_shift`  out  W  ALU operands.
- `alu_os`  out  3  ALU opcode.
- `alu_rd`  in  W  ALU registered result, valid one cycle after issue.

## Operation
- **Opcodes:**
  - 000 add, 001 or, 010 and, 011 xor, 100 nor, 101 logical shift, 110 rotate, 111 reserved (the ALU returns 0).
  - The arbiter passes all opcodes through unchanged and does not check them.
- **Per-requester state (x = a or b):**
  - `inflight_x`: an operation was issued last cycle.
  - `slot_valid_x`, `slot_rd_x`, `slot_zero_x`: the response slot.
- **Eligibility:** `x_req_ready = grant_x`, where requester x is eligible when `!inflight_x && (!slot_valid_x || x_rsp_ready)`. At most one outstanding operation per requester.
- **Arbitration:**
  - If one requester is valid and eligible, it is granted.
  - If both are, the requester indicated by `prio` is granted.
  - After every grant, `prio` points to the other requester.
  - If nothing is granted, `prio` is unchanged.
- **ALU drive (combinational from the grant):**
  - Operands and opcode come from the granted requester.
  - With no grant, `alu_os` = 111 and all operands are 0.
- **Capture:** when `inflight_x` is set, `slot_rd_x <= alu_rd`, `slot_zero_x <= (alu_rd == 0)`, `slot_valid_x <= 1`.
- **Slot pop:** `slot_valid_x` clears on `x_rsp_valid && x_rsp_ready`, unless a capture happens in the same cycle, in which case the capture wins.
- **Response outputs:** `x_rsp_*` come directly from the slot registers.
- **Reset values:** all `inflight`, `slot_valid`, `slot_rd` and `slot_zero` registers are 0, and `prio` = A. Consequently every `rsp_valid`, `rsp_rd` and `rsp_zero` is 0, both `req_ready` are 0 while `reset` is high, and `alu_os` = 111 with operands 0.
- **Reset mid-operation:** an in-flight result is discarded. The ALU output in the cycle after reset is ignored because `inflight` has been cleared.

## Timing
- Grant in cycle N. The ALU samples its inputs at the end of N. `alu_rd` is valid in N+1 and is captured at the end of N+1. `x_rsp_valid` is high from N+2 until popped.
- Latency from request to response is 2 cycles.
- Throughput:
  - Aggregate: 1 grant per cycle, with A and B alternating under contention.
  - Single requester: 1 operation every 2 cycles when `rsp_ready` is held high, because re-grant is allowed in the pop cycle (N+2).
- When a requester's `rsp_ready` is low, its slot blocks that requester only. The other requester continues at full rate.
- `req_ready` has a combinational path from `req_valid`, `rsp_ready` and state. `req_ready` never depends on `alu_rd`.

## Structure
- Shared package `alu_pkg`:
  - Opcode constants `OP_ADD`, `OP_OR`, `OP_AND`, `OP_XOR`, `OP_NOR`, `OP_SHL`, `OP_ROT`, `OP_NOP` (3'b111).
  - Requester index constants `REQ_A` = 0 and `REQ_B` = 1.
- Sub-module `alu_arb_slot`, instantiated twice, holds the `inflight` flag, the response registers and the pop/capture logic, and exports `eligible`.
- The top level contains the round-robin grant, `prio` and the ALU input mux. Total size is about 200 lines.

## Test plan
- **Single requester:** after reset, A requests add 5+7 in cycle 1. `a_req_ready` is 1 in cycle 1. `alu_os` = 000 in cycle 1. `a_rsp_valid` = 1, `a_rsp_rd` = 12, `a_rsp_zero` = 0 in cycle 3. B stays silent throughout.
- **Contention:** A and B request continuously (A xor 0xFF^0xFF, B or 1|2) with `rsp_ready` = 1. Grants alternate A, B, A, B starting with A. A's responses are rd = 0 with zero = 1. B's responses are rd = 3. No grant is lost or duplicated.
- **Backpressure:** `a_rsp_ready` = 0 while A's slot is full. `a_req_ready` stays 0 and B is granted every eligible cycle. Raise `a_rsp_ready` for 1 cycle: the pop occurs and A is re-granted in that same cycle.
- **Reset mid-flight:** grant A (op 101, sr1 = 1, shift = 4), then assert `reset` in the next cycle. `a_rsp_valid` never rises for that operation. After reset, `prio` = A and all outputs match the reset values.
- **Idle:** with no `req_valid`, `alu_os` = 111, `alu_sr1`/`alu_sr2`/`alu_shift` = 0, and `prio` holds its value over 10 idle cycles.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: constants shared by the ALU arbiter and its clients.
//   OP_*  : 3-bit ALU opcodes as driven on alu_os
//   REQ_* : requester indices, also the encoding of the round-robin pointer
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_ROT = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/alu_arb_slot.sv
// alu_arb_slot: per-requester tracking for the shared ALU.
// Holds the in-flight flag for an operation issued last cycle and the
// one-entry response slot that captures alu_rd on the following cycle.
//   clk, reset     : clock, synchronous active-high reset
//   issue          : this requester is granted this cycle
//   alu_rd         : registered ALU result (valid the cycle after issue)
//   rsp_ready      : requester consumes the slot this cycle
//   eligible       : requester may be granted this cycle
//   rsp_valid/rd/zero : response slot contents
module alu_arb_slot #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         issue,
  input  logic [W-1:0] alu_rd,
  input  logic         rsp_ready,
  output logic         eligible,
  output logic         rsp_valid,
  output logic [W-1:0] rsp_rd,
  output logic         rsp_zero
);

  logic         inflight;
  logic         slot_valid;
  logic [W-1:0] slot_rd;
  logic         slot_zero;

  // A new grant is allowed in the pop cycle: the slot frees at the same
  // edge the new operation is issued, and its result lands a cycle later.
  assign eligible = !inflight && (!slot_valid || rsp_ready);

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight   <= 1'b0;
      slot_valid <= 1'b0;
      // NOTE: the result registers are reset too (not just the valid bit)
      // so rsp_rd/rsp_zero read 0 out of reset; a discarded in-flight
      // result is dropped because inflight clears here.
      slot_rd    <= '0;
      slot_zero  <= 1'b0;
    end else begin
      inflight <= issue;
      if (inflight) begin
        // Capture outranks a same-cycle pop: the old entry leaves, the new
        // one takes its place.
        slot_valid <= 1'b1;
        slot_rd    <= alu_rd;
        slot_zero  <= (alu_rd == '0);
      end else if (slot_valid && rsp_ready) begin
        slot_valid <= 1'b0;
      end
    end
  end

  assign rsp_valid = slot_valid;
  assign rsp_rd    = slot_rd;
  assign rsp_zero  = slot_zero;

endmodule

// File: rtl/alu_arb.sv
// alu_arb: round-robin arbiter sharing one single-cycle-latency ALU between
// requester A (execute) and requester B (address/aux unit).
//   clk, reset                 : clock, synchronous active-high reset
//   x_req_valid/ready          : request handshake (ready == grant), x = a/b
//   x_req_op/sr1/sr2/shift     : operation to issue
//   x_rsp_valid/ready          : response handshake from the per-requester slot
//   x_rsp_rd/zero              : result and result==0 flag
//   alu_os/sr1/sr2/shift       : ALU inputs, driven from the granted requester
//   alu_rd                     : ALU registered result, one cycle after issue
module alu_arb
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,

  input  logic         a_req_valid,
  output logic         a_req_ready,
  input  logic [2:0]   a_req_op,
  input  logic [W-1:0] a_req_sr1,
  input  logic [W-1:0] a_req_sr2,
  input  logic [W-1:0] a_req_shift,
  output logic         a_rsp_valid,
  input  logic         a_rsp_ready,
  output logic [W-1:0] a_rsp_rd,
  output logic         a_rsp_zero,

  input  logic         b_req_valid,
  output logic         b_req_ready,
  input  logic [2:0]   b_req_op,
  input  logic [W-1:0] b_req_sr1,
  input  logic [W-1:0] b_req_sr2,
  input  logic [W-1:0] b_req_shift,
  output logic         b_rsp_valid,
  input  logic         b_rsp_ready,
  output logic [W-1:0] b_rsp_rd,
  output logic         b_rsp_zero,

  output logic [W-1:0] alu_sr1,
  output logic [W-1:0] alu_sr2,
  output logic [W-1:0] alu_shift,
  output logic [2:0]   alu_os,
  input  logic [W-1:0] alu_rd
);

  logic prio;
  logic elig_a, elig_b;
  logic want_a, want_b;
  logic grant_a, grant_b;

  // Grants are suppressed while reset is high so no request is accepted
  // into state that is being cleared.
  assign want_a = a_req_valid && elig_a && !reset;
  assign want_b = b_req_valid && elig_b && !reset;

  assign grant_a = want_a && (!want_b || prio == REQ_A);
  assign grant_b = want_b && (!want_a || prio == REQ_B);

  assign a_req_ready = grant_a;
  assign b_req_ready = grant_b;

  always_ff @(posedge clk) begin
    if (reset)        prio <= REQ_A;
    else if (grant_a) prio <= REQ_B;
    else if (grant_b) prio <= REQ_A;
  end

  // NOTE: every output of this always_comb gets a default first, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    alu_os    = OP_NOP;
    alu_sr1   = '0;
    alu_sr2   = '0;
    alu_shift = '0;
    if (grant_a) begin
      alu_os    = a_req_op;
      alu_sr1   = a_req_sr1;
      alu_sr2   = a_req_sr2;
      alu_shift = a_req_shift;
    end else if (grant_b) begin
      alu_os    = b_req_op;
      alu_sr1   = b_req_sr1;
      alu_sr2   = b_req_sr2;
      alu_shift = b_req_shift;
    end
  end

  alu_arb_slot #(.W(W)) u_slot_a (
    .clk       (clk),
    .reset     (reset),
    .issue     (grant_a),
    .alu_rd    (alu_rd),
    .rsp_ready (a_rsp_ready),
    .eligible  (elig_a),
    .rsp_valid (a_rsp_valid),
    .rsp_rd    (a_rsp_rd),
    .rsp_zero  (a_rsp_zero)
  );

  alu_arb_slot #(.W(W)) u_slot_b (
    .clk       (clk),
    .reset     (reset),
    .issue     (grant_b),
    .alu_rd    (alu_rd),
    .rsp_ready (b_rsp_ready),
    .eligible  (elig_b),
    .rsp_valid (b_rsp_valid),
    .rsp_rd    (b_rsp_rd),
    .rsp_zero  (b_rsp_zero)
  );

endmodule
